// File: rtl/niosii_tcm_loader.sv
// Loader for port s2 of the dual-port Nios II instruction TCM. It writes a
// valid/ready word stream to consecutive TCM words. When VERIFY is set it then
// reads the range back and compares the read checksum with the write checksum.
// The CPU is held in reset for the whole operation.
module niosii_tcm_loader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int VERIFY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       word_count,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_W-1:0]     tcm_address,
    output logic                  tcm_chipselect,
    output logic                  tcm_write,
    output logic [DATA_W-1:0]     tcm_writedata,
    output logic [DATA_W/8-1:0]   tcm_byteenable,
    output logic                  tcm_clken,
    input  logic [DATA_W-1:0]     tcm_readdata,
    output logic                  cpu_reset_req,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_VERIFY_RD,
        S_VERIFY_CMP,
        S_DONE
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   base_reg;
    logic [ADDR_W-1:0]   cur_addr;
    logic [ADDR_W:0]     count_reg;
    // Words still to accept in WRITE, reads still to issue in VERIFY_RD.
    logic [ADDR_W:0]     remaining;
    logic [DATA_W-1:0]   sum_w;
    logic [DATA_W-1:0]   sum_r;
    // A read was presented last cycle, so tcm_readdata is valid this cycle.
    logic                sample_pending;
    logic [DATA_W-1:0]   sum_r_total;

    assign tcm_byteenable = '1;
    assign tcm_clken      = 1'b1;

    // Read checksum including the sample that arrives in the current cycle.
    assign sum_r_total = sample_pending ? (sum_r + tcm_readdata) : sum_r;

    // Control FSM. All outputs are registered and describe the current cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            base_reg       <= '0;
            cur_addr       <= '0;
            count_reg      <= '0;
            remaining      <= '0;
            sum_w          <= '0;
            sum_r          <= '0;
            sample_pending <= 1'b0;
            in_ready       <= 1'b0;
            tcm_address    <= '0;
            tcm_chipselect <= 1'b0;
            tcm_write      <= 1'b0;
            tcm_writedata  <= '0;
            cpu_reset_req  <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            done           <= 1'b0;
            sample_pending <= tcm_chipselect & ~tcm_write;
            sum_r          <= sum_r_total;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_reg      <= base_addr;
                        cur_addr      <= base_addr;
                        count_reg     <= word_count;
                        remaining     <= word_count;
                        error         <= 1'b0;
                        sum_w         <= '0;
                        sum_r         <= '0;
                        busy          <= 1'b1;
                        cpu_reset_req <= 1'b1;
                        if (word_count == '0) begin
                            state <= S_DONE;
                        end else begin
                            state    <= S_WRITE;
                            in_ready <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (remaining == '0) begin
                        // The last write is on the bus this cycle.
                        if (VERIFY != 0) begin
                            state          <= S_VERIFY_RD;
                            tcm_chipselect <= 1'b1;
                            tcm_write      <= 1'b0;
                            tcm_address    <= base_reg;
                            remaining      <= count_reg - 1'b1;
                        end else begin
                            state          <= S_DONE;
                            tcm_chipselect <= 1'b0;
                            tcm_write      <= 1'b0;
                        end
                    end else if (in_valid && in_ready) begin
                        tcm_chipselect <= 1'b1;
                        tcm_write      <= 1'b1;
                        tcm_address    <= cur_addr;
                        tcm_writedata  <= in_data;
                        cur_addr       <= cur_addr + 1'b1;
                        sum_w          <= sum_w + in_data;
                        remaining      <= remaining - 1'b1;
                        if (remaining == 1) begin
                            in_ready <= 1'b0;
                        end
                    end else begin
                        tcm_chipselect <= 1'b0;
                        tcm_write      <= 1'b0;
                    end
                end
                S_VERIFY_RD: begin
                    if (remaining != '0) begin
                        tcm_address <= tcm_address + 1'b1;
                        remaining   <= remaining - 1'b1;
                    end else begin
                        tcm_chipselect <= 1'b0;
                        state          <= S_VERIFY_CMP;
                    end
                end
                S_VERIFY_CMP: begin
                    error <= (sum_r_total != sum_w);
                    state <= S_DONE;
                end
                S_DONE: begin
                    busy          <= 1'b0;
                    cpu_reset_req <= 1'b0;
                    done          <= 1'b1;
                    state         <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
